// File: rtl/decoder_scan_seq_if.sv
// Control and slot-select bundle between a scan controller and decoder_scan_seq.
interface decoder_scan_seq_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         mask;
    logic [1:0]         sel;
    logic               en;
    logic               done;

    modport master (
        output start, stop, mode, dwell, mask,
        input  sel, en, done
    );

    modport slave (
        input  start, stop, mode, dwell, mask,
        output sel, en, done
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Scan sequencer feeding a 2-to-4 decoder: walks the unmasked slots in ascending
// order, holding each for dwell+1 cycles, in one-shot or continuous passes.
module decoder_scan_seq #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    decoder_scan_seq_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         state_q, state_n;
    logic [DWELL_W-1:0] cnt_q, cnt_n;
    logic [DWELL_W-1:0] dwell_l_q, dwell_l_n;
    logic [3:0]         mask_l_q, mask_l_n;
    logic               mode_l_q, mode_l_n;
    logic [1:0]         sel_q, sel_n;
    logic               en_q, en_n;
    logic               done_q, done_n;

    logic [1:0]         first_in_c;
    logic [1:0]         first_l_c;
    logic [1:0]         above_c;
    logic               has_above_c;

    // Lowest set bit of a 4-bit mask (0 when the mask is empty).
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next active slot strictly above the current one in the latched mask.
    always_comb begin
        above_c     = 2'd0;
        has_above_c = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_l_q[i] && (3'(i) > {1'b0, sel_q})) begin
                above_c     = 2'(i);
                has_above_c = 1'b1;
            end
        end
    end

    assign first_in_c = lowest_set(bus.mask);
    assign first_l_c  = lowest_set(mask_l_q);

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        dwell_l_n = dwell_l_q;
        mask_l_n  = mask_l_q;
        mode_l_n  = mode_l_q;
        sel_n     = sel_q;
        en_n      = en_q;
        done_n    = 1'b0;

        case (state_q)
            S_IDLE: begin
                en_n = 1'b0;
                if (bus.start && !bus.stop && (bus.mask != 4'd0)) begin
                    mode_l_n  = bus.mode;
                    dwell_l_n = bus.dwell;
                    mask_l_n  = bus.mask;
                    sel_n     = first_in_c;
                    cnt_n     = '0;
                    en_n      = 1'b1;
                    state_n   = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_n = S_IDLE;
                    en_n    = 1'b0;
                    sel_n   = 2'd0;
                    cnt_n   = '0;
                end else if (cnt_q != dwell_l_q) begin
                    cnt_n = cnt_q + DWELL_W'(1);
                end else begin
                    cnt_n = '0;
                    if (has_above_c) begin
                        sel_n = above_c;
                    end else begin
                        done_n = 1'b1;
                        if (mode_l_q) begin
                            sel_n = first_l_c;
                        end else begin
                            state_n = S_IDLE;
                            en_n    = 1'b0;
                            sel_n   = 2'd0;
                        end
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                en_n    = 1'b0;
                sel_n   = 2'd0;
                cnt_n   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dwell_l_q <= '0;
            mask_l_q  <= 4'd0;
            mode_l_q  <= 1'b0;
            sel_q     <= 2'd0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            dwell_l_q <= dwell_l_n;
            mask_l_q  <= mask_l_n;
            mode_l_q  <= mode_l_n;
            sel_q     <= sel_n;
            en_q      <= en_n;
            done_q    <= done_n;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.en   = en_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed-vector bench for decoder_scan_seq with a queue-based scoreboard.
module tb_decoder_scan_seq;
    localparam int unsigned DWELL_W = 8;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   vec;
    exp_t expq[$];

    decoder_scan_seq_if #(.DWELL_W(DWELL_W)) bus ();

    decoder_scan_seq #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs; the given outputs are required after the next edge.
    task automatic step(input logic r, input logic st, input logic sp, input logic md,
                        input logic [DWELL_W-1:0] dw, input logic [3:0] mk,
                        input logic [1:0] es, input logic ee, input logic ed);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bus.start = st;
        bus.stop  = sp;
        bus.mode  = md;
        bus.dwell = dw;
        bus.mask  = mk;
        @(posedge clk);
        e.sel  = es;
        e.en   = ee;
        e.done = ed;
        expq.push_back(e);
    endtask

    // Idle-input cycle: only the expected outputs vary.
    task automatic idle(input logic [1:0] es, input logic ee, input logic ed);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, es, ee, ed);
    endtask

    // Monitor: outputs are presented every cycle, so each negedge consumes one entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                total++;
                vec++;
                if ({bus.sel, bus.en, bus.done} !== {e.sel, e.en, e.done}) begin
                    bad++;
                    $display("FAIL vec%0d: got sel=%0d en=%0b done=%0b, want sel=%0d en=%0b done=%0b",
                             vec, bus.sel, bus.en, bus.done, e.sel, e.en, e.done);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        total     = 0;
        bad       = 0;
        vec       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b0;
        bus.dwell = '0;
        bus.mask  = 4'd0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 4'hF, 2'd0, 1'b0, 1'b0);

        // One-shot full scan, dwell 0.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'hF, 2'd0, 1'b1, 1'b0);
        idle(2'd1, 1'b1, 1'b0);
        idle(2'd2, 1'b1, 1'b0);
        idle(2'd3, 1'b1, 1'b0);
        idle(2'd0, 1'b0, 1'b1);
        idle(2'd0, 1'b0, 1'b0);

        // Masked dwell scan; inputs wiggled mid-run must be ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 4'hA, 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 4'hF, 2'd1, 1'b1, 1'b0);
        idle(2'd1, 1'b1, 1'b0);
        idle(2'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 4'h1, 2'd3, 1'b1, 1'b0);
        idle(2'd3, 1'b1, 1'b0);
        idle(2'd0, 1'b0, 1'b1);
        idle(2'd0, 1'b0, 1'b0);

        // Continuous wrap, then stop at cnt=0 on slot 2.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 4'h5, 2'd0, 1'b1, 1'b0);
        idle(2'd0, 1'b1, 1'b0);
        idle(2'd2, 1'b1, 1'b0);
        idle(2'd2, 1'b1, 1'b0);
        idle(2'd0, 1'b1, 1'b1);
        idle(2'd0, 1'b1, 1'b0);
        idle(2'd2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        // Empty-mask start and start+stop are both ignored in IDLE.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 4'h0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 4'hF, 2'd0, 1'b0, 1'b0);
        idle(2'd0, 1'b0, 1'b0);

        // Reset mid-run: no done pulse.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 4'hF, 2'd0, 1'b1, 1'b0);
        idle(2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        idle(2'd0, 1'b0, 1'b0);

        // Single-bit mask, continuous: sel fixed at 3, done every 4 cycles.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 4'h8, 2'd3, 1'b1, 1'b0);
        for (int p = 0; p < 2; p++) begin
            idle(2'd3, 1'b1, 1'b0);
            idle(2'd3, 1'b1, 1'b0);
            idle(2'd3, 1'b1, 1'b0);
            idle(2'd3, 1'b1, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0, 2'd0, 1'b0, 1'b0);

        // Maximum dwell, one-shot over slots 0 and 1.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 4'h3, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 255; i++) idle(2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) idle(2'd1, 1'b1, 1'b0);
        idle(2'd0, 1'b0, 1'b1);

        // New start accepted at the edge ending a one-shot done cycle.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'h4, 2'd2, 1'b1, 1'b0);
        idle(2'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'h1, 2'd0, 1'b1, 1'b0);
        idle(2'd0, 1'b0, 1'b1);
        idle(2'd0, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (expq.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        if (expq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
